// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back path: widths and arbiter state encoding.
package regfile_writeback_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [0:0] {
    ALU_PRI,
    LSU_PRI
  } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module wb_scoreboard
  import regfile_writeback_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_valid_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_rd_i] = 1'b0;
    // A new issue to the register being retired keeps it pending.
    if (set_valid_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard_o = (busy_q[rs1_i] & (rs1_i != '0)) | (busy_q[rs2_i] & (rs2_i != '0));

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter between ALU and long-latency results, with starvation guard and scoreboard.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wa,
  output logic [XLEN-1:0]       wd
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic                  alu_acc, lsu_acc, lsu_stall;

  always_comb begin
    alu_ready = 1'b1;
    lsu_ready = 1'b0;
    state_d   = state_q;
    if (!rst) begin
      unique case (state_q)
        ALU_PRI: begin
          lsu_ready = lsu_valid & ~alu_valid;
          if ((cnt_q == Limit) && lsu_valid && !lsu_ready) state_d = LSU_PRI;
        end
        LSU_PRI: begin
          // The held LSU result is always taken here, so return next cycle.
          alu_ready = 1'b0;
          lsu_ready = 1'b1;
          state_d   = ALU_PRI;
        end
      endcase
    end
  end

  assign alu_acc   = alu_valid & alu_ready;
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign lsu_stall = lsu_valid & ~lsu_ready;

  always_comb begin
    cnt_d = '0;
    if (lsu_stall) cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
  end

  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (alu_acc && (alu_rd != '0)) begin
      we_d = 1'b1;
      wa_d = alu_rd;
      wd_d = alu_data;
    end else if (lsu_acc && (lsu_rd != '0)) begin
      we_d = 1'b1;
      wa_d = lsu_rd;
      wd_d = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALU_PRI;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;

  wb_scoreboard u_scoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_valid_i(issue_valid),
    .set_rd_i   (issue_rd),
    .clr_valid_i(we_q),
    .clr_rd_i   (wa_q),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .hazard_o   (hazard)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench: per-cycle vector table plus starvation and mid-stream reset sequences.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2, wa;
  logic [31:0] alu_data, lsu_data, wd;
  logic        issue_valid, hazard, we;

  int n_checks = 0;
  int n_fail   = 0;

  logic        hold_chk = 1'b0;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  always #5 clk = ~clk;

  regfile_writeback #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .hazard     (hazard),
    .we         (we),
    .wa         (wa),
    .wd         (wd)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_ar;
    logic        e_lr;
    logic        e_hz;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad, logic lv,
                              logic [4:0] lrd, logic [31:0] ld, logic iv, logic [4:0] ird,
                              logic [4:0] s1, logic [4:0] s2, logic e_ar, logic e_lr,
                              logic e_hz, logic e_we, logic [4:0] e_wa, logic [31:0] e_wd);
    vec_t v;
    v.av = av;   v.ard = ard; v.ad = ad;   v.lv = lv;     v.lrd = lrd;   v.ld = ld;
    v.iv = iv;   v.ird = ird; v.s1 = s1;   v.s2 = s2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_hz = e_hz; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_valid = v.iv; issue_rd = v.ird; rs1 = v.s1; rs2 = v.s2;
  endtask

  // Let combinational outputs settle, then check the held-LSU stability rule.
  task automatic settle();
    #1;
    if (hold_chk && lsu_valid) begin
      chk("lsu_hold_rd", {27'd0, lsu_rd}, {27'd0, hold_rd});
      chk("lsu_hold_data", lsu_data, hold_data);
    end
  endtask

  task automatic tick();
    hold_chk  = lsu_valid & ~lsu_ready & ~rst;
    hold_rd   = lsu_rd;
    hold_data = lsu_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    lsu_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wa", {27'd0, wa}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    rst = 1'b0;
    lsu_valid = 1'b0;

    //          av ard    ad          lv lrd    ld       iv ird    s1     s2     ar lr hz we wa     wd
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 32'h0));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 32'h0));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd6, 5'd5, 5'd0, 1, 0, 1, 0, 5'd0, 32'h0));
    vq.push_back(mk(1, 5'd6, 32'h4,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd6, 1, 0, 1, 1, 5'd6, 32'h4));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd6, 1, 0, 1, 0, 5'd6, 32'h4));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd6, 1, 0, 0, 0, 5'd6, 32'h4));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd7, 5'd0, 5'd0, 1, 0, 0, 0, 5'd6, 32'h4));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd8, 5'd7, 5'd0, 1, 0, 1, 0, 5'd6, 32'h4));
    vq.push_back(mk(1, 5'd7, 32'h77,      1, 5'd8, 32'h88, 0, 5'd0, 5'd7, 5'd8, 1, 0, 1, 1, 5'd7, 32'h77));
    vq.push_back(mk(0, 5'd0, 32'h0,       1, 5'd8, 32'h88, 0, 5'd0, 5'd0, 5'd8, 1, 1, 1, 1, 5'd8, 32'h88));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 5'd0, 1, 0, 0, 0, 5'd8, 32'h88));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd8, 1, 0, 0, 0, 5'd8, 32'h88));
    vq.push_back(mk(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0, 1, 0, 1, 0, 5'd8, 32'h88));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd5, 5'd0, 1, 0, 1, 0, 5'd8, 32'h88));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd9, 5'd0, 5'd0, 1, 0, 0, 0, 5'd8, 32'h88));
    vq.push_back(mk(1, 5'd9, 32'h99,      0, 5'd0, 32'h0,  0, 5'd0, 5'd9, 5'd0, 1, 0, 1, 1, 5'd9, 32'h99));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  1, 5'd9, 5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 32'h99));
    vq.push_back(mk(0, 5'd0, 32'h0,       0, 5'd0, 32'h0,  0, 5'd0, 5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 32'h99));

    foreach (vq[i]) begin
      drive(vq[i]);
      settle();
      chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vq[i].e_ar});
      chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vq[i].e_lr});
      chk($sformatf("v%0d_hazard", i), {31'd0, hazard}, {31'd0, vq[i].e_hz});
      tick();
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vq[i].e_we});
      chk($sformatf("v%0d_wa", i), {27'd0, wa}, {27'd0, vq[i].e_wa});
      chk($sformatf("v%0d_wd", i), wd, vq[i].e_wd);
    end

    // Starvation: continuous ALU stream, LSU result held; taken in the 6th cycle.
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB0B0;
    alu_valid = 1'b1; alu_rd = 5'd10;
    for (int i = 1; i <= 7; i++) begin
      alu_data = 32'(i);
      settle();
      chk($sformatf("starve%0d_alu_ready", i), {31'd0, alu_ready}, (i != 6) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d_lsu_ready", i), {31'd0, lsu_ready}, (i == 6) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("starve%0d_we", i), {31'd0, we}, 32'd1);
      chk($sformatf("starve%0d_wa", i), {27'd0, wa}, (i == 6) ? 32'd11 : 32'd10);
      chk($sformatf("starve%0d_wd", i), wd, (i == 6) ? 32'hB0B0 : 32'(i));
      if (i == 6) lsu_valid = 1'b0;
    end

    // Reset mid-stream with an ALU result being offered and an issue pending.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd12;
    settle();
    tick();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h1313;
    lsu_valid = 1'b1; lsu_rd = 5'd15; lsu_data = 32'h1515;
    issue_valid = 1'b1; issue_rd = 5'd14;
    settle();
    chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("midrst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    chk("midrst_we", {31'd0, we}, 32'd0);
    chk("midrst_wa", {27'd0, wa}, 32'd0);
    chk("midrst_wd", wd, 32'd0);
    rst = 1'b0;
    idle();
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r);
      settle();
      chk($sformatf("midrst_busy%0d", r), {31'd0, hazard}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
